// File: rtl/priority_encoder_8to3.sv
// -----------------------------------------------------------------------------
// priority_encoder_8to3
//   Registered highest-priority encoder. Reports the index of the most
//   significant asserted bit of the request vector, a valid flag, and a
//   one-hot mask of the winning bit. Single-cycle latency; every output
//   comes straight from a flop, so there is no combinational d -> output path.
//
// Ports
//   clk     in   1      clock, rising edge
//   rst     in   1      synchronous reset, active-high (beats the d sample)
//   d       in   WIDTH  request vector, bit WIDTH-1 = highest priority
//   y       out  IDX_W  index of highest set bit of d (0 when d == 0)
//   valid   out  1      sampled d had at least one bit set
//   onehot  out  WIDTH  1 << y when valid, else all zeros
// -----------------------------------------------------------------------------
module priority_encoder_8to3 #(
  parameter int WIDTH = 8,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [IDX_W-1:0] y,
  output logic             valid,
  output logic [WIDTH-1:0] onehot
);

  logic [IDX_W-1:0] y_d,      y_q;
  logic             valid_d,  valid_q;
  logic [WIDTH-1:0] onehot_d, onehot_q;

  // Scan from the LSB upward; each hit overwrites the previous one, so the
  // last hit standing is the most significant set bit. Works for any WIDTH.
  always_comb begin
    y_d      = '0;
    valid_d  = 1'b0;
    onehot_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (d[i]) begin
        y_d         = IDX_W'(i);
        valid_d     = 1'b1;
        onehot_d    = '0;
        onehot_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q      <= '0;
      valid_q  <= 1'b0;
      onehot_q <= '0;
    end else begin
      y_q      <= y_d;
      valid_q  <= valid_d;
      onehot_q <= onehot_d;
    end
  end

  assign y      = y_q;
  assign valid  = valid_q;
  assign onehot = onehot_q;

endmodule

// File: tb/tb_priority_encoder_8to3.sv
module tb_priority_encoder_8to3;

  logic       clk;
  logic       rst;
  logic [7:0] d;
  logic [2:0] y;
  logic       valid;
  logic [7:0] onehot;

  int checks   = 0;
  int failures = 0;

  priority_encoder_8to3 #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .d      (d),
    .y      (y),
    .valid  (valid),
    .onehot (onehot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive on the falling edge, then wait past the next rising edge to sample.
  task automatic apply(input logic r, input logic [7:0] dv);
    @(negedge clk);
    rst = r;
    d   = dv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      apply(1'b1, 8'hFF);
      checks++;
      if (y !== 3'd0 || valid !== 1'b0 || onehot !== 8'h00) begin
        failures++;
        $display("FAIL reset_hold cyc%0d got y=%0d v=%b oh=%h want y=0 v=0 oh=00", k, y, valid, onehot);
      end
    end
    apply(1'b0, 8'hFF);
    checks++;
    if (y !== 3'd7 || valid !== 1'b1 || onehot !== 8'h80) begin
      failures++;
      $display("FAIL reset_release got y=%0d v=%b oh=%h want y=7 v=1 oh=80", y, valid, onehot);
    end
  endtask

  task automatic test_zero();
    apply(1'b0, 8'h00);
    checks++;
    if (y !== 3'd0 || valid !== 1'b0 || onehot !== 8'h00) begin
      failures++;
      $display("FAIL zero_input got y=%0d v=%b oh=%h want y=0 v=0 oh=00", y, valid, onehot);
    end
  endtask

  task automatic test_walking_one();
    logic [7:0] dv;
    for (int i = 0; i < 8; i++) begin
      dv = 8'h01 << i;
      apply(1'b0, dv);
      checks++;
      if (y !== 3'(i) || valid !== 1'b1 || onehot !== dv) begin
        failures++;
        $display("FAIL walking_one i=%0d got y=%0d v=%b oh=%h want y=%0d v=1 oh=%h", i, y, valid, onehot, i, dv);
      end
    end
  endtask

  task automatic test_priority();
    logic [7:0] dv [4];
    logic [2:0] ye [4];
    logic [7:0] ohe;
    dv = '{8'hFF, 8'h2C, 8'h03, 8'h81};
    ye = '{3'd7,  3'd5,  3'd1,  3'd7};
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, dv[i]);
      ohe = 8'h01 << ye[i];
      checks++;
      if (y !== ye[i] || valid !== 1'b1 || onehot !== ohe) begin
        failures++;
        $display("FAIL priority d=%h got y=%0d v=%b oh=%h want y=%0d v=1 oh=%h", dv[i], y, valid, onehot, ye[i], ohe);
      end
    end
  endtask

  // Consecutive changes; also checks outputs hold the previous result until
  // the edge that samples the new d.
  task automatic test_back_to_back();
    logic [7:0] dv [3];
    logic [2:0] ye [3];
    logic       ve [3];
    logic [7:0] ohe [3];
    logic [2:0] yp;
    logic       vp;
    dv  = '{8'h01, 8'h40, 8'h00};
    ye  = '{3'd0,  3'd6,  3'd0};
    ve  = '{1'b1,  1'b1,  1'b0};
    ohe = '{8'h01, 8'h40, 8'h00};
    apply(1'b0, 8'h80);
    yp = 3'd7;
    vp = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      d = dv[i];
      #1;
      checks++;
      if (y !== yp || valid !== vp) begin
        failures++;
        $display("FAIL latency_hold i=%0d got y=%0d v=%b want y=%0d v=%b", i, y, valid, yp, vp);
      end
      @(posedge clk);
      #1;
      checks++;
      if (y !== ye[i] || valid !== ve[i] || onehot !== ohe[i]) begin
        failures++;
        $display("FAIL back_to_back i=%0d got y=%0d v=%b oh=%h want y=%0d v=%b oh=%h", i, y, valid, onehot, ye[i], ve[i], ohe[i]);
      end
      yp = ye[i];
      vp = ve[i];
    end
  endtask

  task automatic test_midstream_reset();
    apply(1'b0, 8'h10);
    checks++;
    if (y !== 3'd4 || valid !== 1'b1 || onehot !== 8'h10) begin
      failures++;
      $display("FAIL midrst_pre got y=%0d v=%b oh=%h want y=4 v=1 oh=10", y, valid, onehot);
    end
    apply(1'b1, 8'h10);
    checks++;
    if (y !== 3'd0 || valid !== 1'b0 || onehot !== 8'h00) begin
      failures++;
      $display("FAIL midrst_assert got y=%0d v=%b oh=%h want y=0 v=0 oh=00", y, valid, onehot);
    end
    apply(1'b0, 8'h10);
    checks++;
    if (y !== 3'd4 || valid !== 1'b1 || onehot !== 8'h10) begin
      failures++;
      $display("FAIL midrst_release got y=%0d v=%b oh=%h want y=4 v=1 oh=10", y, valid, onehot);
    end
  endtask

  initial begin
    rst = 1'b1;
    d   = 8'h00;
    test_reset();
    test_zero();
    test_walking_one();
    test_priority();
    test_back_to_back();
    test_midstream_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
